// File: rtl/data_access_unit_if.sv
// Bus bundle between the M stage, the data memory and the data access unit.
// The slave modport is the access unit; the master modport is whoever drives the pipeline/memory side.
interface data_access_unit_if #(
   parameter int N = 32,
   parameter int V = 4,
   parameter int A = 32
);
   logic           MemReadM;
   logic           MemWriteM;
   logic           VecM;
   logic [A-1:0]   AddrM;
   logic [N-1:0]   WriteDataM;
   logic [V*N-1:0] WriteDataVM;
   logic [A-1:0]   mem_addr;
   logic [N-1:0]   mem_wdata;
   logic           mem_we;
   logic [N-1:0]   mem_rdata;
   logic [N-1:0]   ReadDataM;
   logic [V*N-1:0] ReadDataVM;
   logic           BusyDA;
   logic           DoneDA;

   modport slave (
      input  MemReadM, MemWriteM, VecM, AddrM, WriteDataM, WriteDataVM, mem_rdata,
      output mem_addr, mem_wdata, mem_we, ReadDataM, ReadDataVM, BusyDA, DoneDA
   );

   modport master (
      output MemReadM, MemWriteM, VecM, AddrM, WriteDataM, WriteDataVM, mem_rdata,
      input  mem_addr, mem_wdata, mem_we, ReadDataM, ReadDataVM, BusyDA, DoneDA
   );
endinterface

// File: rtl/data_access_unit.sv
// Memory-stage data access controller: scalar accesses pass through, vector accesses
// are serialized into V word beats while BusyDA stalls the pipeline.
module data_access_unit #(
   parameter int N = 32,
   parameter int V = 4,
   parameter int A = 32
) (
   input logic              clk,
   input logic              rst,
   data_access_unit_if.slave bus
);
   localparam int BW  = N / 8;
   localparam int OFS = $clog2(BW);
   localparam int CW  = $clog2(V) + 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WRITE     = 3'd1,
      READ      = 3'd2,
      READ_LAST = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [A-1:0]   base_q;
   logic [V*N-1:0] wdata_q;
   logic [V*N-1:0] rdvm_q;

   logic           vreq;
   logic [A-1:0]   base_d;
   logic [A-1:0]   beat_addr;
   logic [N-1:0]   lane_wdata;
   logic [A-1:0]   mem_addr_c;
   logic [N-1:0]   mem_wdata_c;
   logic           mem_we_c;
   logic           busy_c;
   logic           done_c;

   assign vreq      = bus.VecM & (bus.MemReadM | bus.MemWriteM);
   assign base_d    = bus.AddrM & ~A'(BW - 1);
   // Beat address wraps naturally in A bits.
   assign beat_addr = base_q + (A'(cnt_q) << OFS);

   // Select the captured store lane addressed by the beat counter.
   always_comb begin
      lane_wdata = {N{1'b0}};
      for (int k = 0; k < V; k++) begin
         lane_wdata = (cnt_q == CW'(k)) ? wdata_q[k*N +: N] : lane_wdata;
      end
   end

   // Memory-side and handshake outputs; the scalar path and beat 0 must be same-cycle.
   always_comb begin
      mem_addr_c  = {A{1'b0}};
      mem_wdata_c = {N{1'b0}};
      mem_we_c    = 1'b0;
      busy_c      = 1'b0;
      done_c      = 1'b0;
      if (rst) begin
         busy_c = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (vreq) begin
                  busy_c      = 1'b1;
                  mem_addr_c  = base_d;
                  mem_we_c    = bus.MemWriteM;
                  mem_wdata_c = bus.WriteDataVM[N-1:0];
               end else begin
                  mem_addr_c  = bus.AddrM;
                  mem_wdata_c = bus.WriteDataM;
                  mem_we_c    = bus.MemWriteM & ~bus.VecM;
               end
            end
            WRITE: begin
               busy_c      = 1'b1;
               mem_addr_c  = beat_addr;
               mem_wdata_c = lane_wdata;
               mem_we_c    = 1'b1;
            end
            READ: begin
               busy_c     = 1'b1;
               mem_addr_c = beat_addr;
            end
            READ_LAST: busy_c = 1'b1;
            DONE:      done_c = 1'b1;
            default:   busy_c = 1'b0;
         endcase
      end
   end

   // Sequencer: captures the request in IDLE, then walks the beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= {CW{1'b0}};
         base_q  <= {A{1'b0}};
         wdata_q <= {(V*N){1'b0}};
         rdvm_q  <= {(V*N){1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (vreq) begin
                  base_q  <= base_d;
                  wdata_q <= bus.WriteDataVM;
                  cnt_q   <= CW'(1);
                  state_q <= bus.MemWriteM ? WRITE : READ;
               end else begin
                  state_q <= IDLE;
               end
            end
            WRITE: begin
               if (cnt_q == CW'(V - 1)) begin
                  cnt_q   <= {CW{1'b0}};
                  state_q <= DONE;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            READ: begin
               // Data for beat k-1 arrives while beat k is issued.
               for (int k = 0; k < V - 1; k++) begin
                  if (cnt_q == CW'(k + 1)) begin
                     rdvm_q[k*N +: N] <= bus.mem_rdata;
                  end
               end
               if (cnt_q == CW'(V - 1)) begin
                  cnt_q   <= {CW{1'b0}};
                  state_q <= READ_LAST;
               end else begin
                  cnt_q   <= cnt_q + CW'(1);
               end
            end
            READ_LAST: begin
               rdvm_q[(V-1)*N +: N] <= bus.mem_rdata;
               state_q              <= DONE;
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.mem_addr   = mem_addr_c;
   assign bus.mem_wdata  = mem_wdata_c;
   assign bus.mem_we     = mem_we_c;
   assign bus.BusyDA     = busy_c;
   assign bus.DoneDA     = done_c;
   assign bus.ReadDataM  = bus.mem_rdata;
   assign bus.ReadDataVM = rdvm_q;
endmodule

// File: tb/tb_data_access_unit.sv
// Directed bench for data_access_unit with a synchronous-read word memory model.
module tb_data_access_unit;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   logic        pre_we;
   logic [31:0] pre_addr;
   logic [31:0] pre_data;
   logic [31:0] mem [0:1023];

   data_access_unit_if #(.N(32), .V(4), .A(32)) bus ();

   data_access_unit #(.N(32), .V(4), .A(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) begin
      bus.mem_rdata <= mem[bus.mem_addr[11:2]];
      if (pre_we) mem[pre_addr[11:2]] <= pre_data;
      else if (bus.mem_we) mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
   end

   task automatic drive(input logic rd, input logic wr, input logic vec, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [127:0] wdv);
      bus.MemReadM    = rd;
      bus.MemWriteM   = wr;
      bus.VecM        = vec;
      bus.AddrM       = addr;
      bus.WriteDataM  = wd;
      bus.WriteDataVM = wdv;
   endtask

   task automatic preload(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = addr; pre_data = data;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h1234_5678, 128'h0);
      @(negedge clk); #1;
      total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", bus.mem_we); end
      total++; if (bus.BusyDA !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.BusyDA); end
      total++; if (bus.DoneDA !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.DoneDA); end
      total++; if (bus.ReadDataVM !== 128'h0) begin bad++; $display("FAIL reset_rdvm: got %h want 0", bus.ReadDataVM); end
      total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.mem_addr); end
      rst = 1'b0;
      @(negedge clk); #1;
      total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20) begin
         bad++; $display("FAIL reset_idle_scalar: got we=%b addr=%h want we=1 addr=00000020", bus.mem_we, bus.mem_addr);
      end
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
   endtask

   task automatic test_vector_store();
      logic [31:0] exp_w [4] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 128'h44444444_33333333_22222222_11111111);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         if (k == 1) begin
            bus.AddrM = 32'h0BAD_0000;
            bus.WriteDataVM = {4{32'hFFFF_FFFF}};
         end
         #1;
         total++; if (bus.BusyDA !== 1'b1 || bus.mem_we !== 1'b1) begin
            bad++; $display("FAIL store_busy_we beat %0d: got busy=%b we=%b want 1/1", k, bus.BusyDA, bus.mem_we);
         end
         total++; if (bus.mem_addr !== 32'h100 + 32'(4 * k)) begin
            bad++; $display("FAIL store_addr beat %0d: got %h want %h", k, bus.mem_addr, 32'h100 + 32'(4 * k));
         end
         total++; if (bus.mem_wdata !== exp_w[k]) begin
            bad++; $display("FAIL store_wdata beat %0d: got %h want %h", k, bus.mem_wdata, exp_w[k]);
         end
      end
      @(negedge clk); #1;
      total++; if (bus.BusyDA !== 1'b0 || bus.DoneDA !== 1'b1 || bus.mem_we !== 1'b0) begin
         bad++; $display("FAIL store_done: got busy=%b done=%b we=%b want 0/1/0", bus.BusyDA, bus.DoneDA, bus.mem_we);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
      #1;
      total++; if (bus.DoneDA !== 1'b0 || bus.BusyDA !== 1'b0) begin
         bad++; $display("FAIL store_after: got busy=%b done=%b want 0/0", bus.BusyDA, bus.DoneDA);
      end
      for (int k = 0; k < 4; k++) begin
         total++; if (mem[10'h40 + 10'(k)] !== exp_w[k]) begin
            bad++; $display("FAIL store_mem word %0d: got %h want %h", k, mem[10'h40 + 10'(k)], exp_w[k]);
         end
      end
      total++; if (bus.ReadDataVM !== 128'h0) begin bad++; $display("FAIL store_rdvm_hold: got %h want 0", bus.ReadDataVM); end
   endtask

   task automatic test_vector_load();
      for (int k = 0; k < 4; k++) preload(32'h200 + 32'(4 * k), 32'hA0 + 32'(k));
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 128'h0);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         total++; if (bus.BusyDA !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++; $display("FAIL load_busy_we cycle %0d: got busy=%b we=%b want 1/0", k, bus.BusyDA, bus.mem_we);
         end
         if (k < 4) begin
            total++; if (bus.mem_addr !== 32'h200 + 32'(4 * k)) begin
               bad++; $display("FAIL load_addr beat %0d: got %h want %h", k, bus.mem_addr, 32'h200 + 32'(4 * k));
            end
         end
      end
      @(negedge clk); #1;
      total++; if (bus.DoneDA !== 1'b1 || bus.BusyDA !== 1'b0 || bus.mem_we !== 1'b0) begin
         bad++; $display("FAIL load_done: got busy=%b done=%b we=%b want 0/1/0", bus.BusyDA, bus.DoneDA, bus.mem_we);
      end
      total++; if (bus.ReadDataVM !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         bad++; $display("FAIL load_rdvm: got %h want 000000a3000000a2000000a1000000a0", bus.ReadDataVM);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
   endtask

   task automatic test_scalar();
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 128'h0);
      #1;
      total++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h20 || bus.BusyDA !== 1'b0) begin
         bad++; $display("FAIL scalar_store: got we=%b addr=%h busy=%b want 1/00000020/0", bus.mem_we, bus.mem_addr, bus.BusyDA);
      end
      total++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL scalar_wdata: got %h want deadbeef", bus.mem_wdata);
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 128'h0);
      #1;
      total++; if (bus.mem_we !== 1'b0 || bus.BusyDA !== 1'b0) begin
         bad++; $display("FAIL scalar_load_issue: got we=%b busy=%b want 0/0", bus.mem_we, bus.BusyDA);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
      #1;
      total++; if (bus.ReadDataM !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL scalar_rdata: got %h want deadbeef", bus.ReadDataM);
      end
      total++; if (bus.ReadDataVM !== 128'h000000A3_000000A2_000000A1_000000A0) begin
         bad++; $display("FAIL scalar_rdvm_hold: got %h want 000000a3000000a2000000a1000000a0", bus.ReadDataVM);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_a [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      logic [31:0] exp_w [4] = '{32'hC000_0000, 32'hC111_1111, 32'hC222_2222, 32'hC333_3333};
      for (int k = 0; k < 4; k++) preload(32'h300 + 32'(4 * k), 32'hB0 + 32'(k));
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 128'h0);
      repeat (5) @(negedge clk);
      #1;
      total++; if (bus.DoneDA !== 1'b1 || bus.BusyDA !== 1'b0 || bus.mem_we !== 1'b0) begin
         bad++; $display("FAIL b2b_done_no_reissue: got busy=%b done=%b we=%b want 0/1/0", bus.BusyDA, bus.DoneDA, bus.mem_we);
      end
      total++; if (bus.ReadDataVM !== 128'h000000B3_000000B2_000000B1_000000B0) begin
         bad++; $display("FAIL b2b_rdvm: got %h want 000000b3000000b2000000b1000000b0", bus.ReadDataVM);
      end
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0, 128'hC3333333_C2222222_C1111111_C0000000);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         total++; if (bus.BusyDA !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== exp_a[k] || bus.mem_wdata !== exp_w[k]) begin
            bad++; $display("FAIL b2b_wrap beat %0d: got busy=%b we=%b addr=%h data=%h want 1/1/%h/%h",
                            k, bus.BusyDA, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_a[k], exp_w[k]);
         end
      end
      @(negedge clk); #1;
      total++; if (bus.DoneDA !== 1'b1) begin bad++; $display("FAIL b2b_store_done: got %b want 1", bus.DoneDA); end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
      total++; if (mem[10'h000] !== 32'hC222_2222 || mem[10'h3FE] !== 32'hC000_0000) begin
         bad++; $display("FAIL b2b_wrap_mem: got [0]=%h [FFFFFFF8]=%h want c2222222/c0000000", mem[10'h000], mem[10'h3FE]);
      end
      total++; if (bus.ReadDataVM !== 128'h000000B3_000000B2_000000B1_000000B0) begin
         bad++; $display("FAIL b2b_rdvm_hold: got %h want 000000b3000000b2000000b1000000b0", bus.ReadDataVM);
      end
   endtask

   task automatic test_abort();
      preload(32'h408, 32'hCAFE_0002);
      preload(32'h40C, 32'hCAFE_0003);
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 128'h88888888_77777777_66666666_55555555);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++; if (bus.BusyDA !== 1'b0 || bus.mem_we !== 1'b0 || bus.DoneDA !== 1'b0) begin
         bad++; $display("FAIL abort_outputs: got busy=%b we=%b done=%b want 0/0/0", bus.BusyDA, bus.mem_we, bus.DoneDA);
      end
      total++; if (bus.ReadDataVM !== 128'h0 || bus.mem_addr !== 32'h0) begin
         bad++; $display("FAIL abort_regs: got rdvm=%h addr=%h want 0/0", bus.ReadDataVM, bus.mem_addr);
      end
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
      #1;
      total++; if (bus.BusyDA !== 1'b0) begin bad++; $display("FAIL abort_idle: got busy=%b want 0", bus.BusyDA); end
      total++; if (mem[10'h100] !== 32'h5555_5555 || mem[10'h101] !== 32'h6666_6666) begin
         bad++; $display("FAIL abort_early_beats: got %h %h want 55555555 66666666", mem[10'h100], mem[10'h101]);
      end
      total++; if (mem[10'h102] !== 32'hCAFE_0002 || mem[10'h103] !== 32'hCAFE_0003) begin
         bad++; $display("FAIL abort_late_beats: got %h %h want cafe0002 cafe0003", mem[10'h102], mem[10'h103]);
      end
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 128'h0);
      repeat (5) @(negedge clk);
      #1;
      total++; if (bus.DoneDA !== 1'b1 || bus.ReadDataVM !== 128'hCAFE0003_CAFE0002_66666666_55555555) begin
         bad++; $display("FAIL abort_reload: got done=%b rdvm=%h want 1/cafe0003cafe00026666666655555555", bus.DoneDA, bus.ReadDataVM);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 128'h0);
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      pre_we = 1'b0;
      pre_addr = 32'h0;
      pre_data = 32'h0;
      test_reset();
      test_vector_store();
      test_vector_load();
      test_scalar();
      test_back_to_back();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/data_access_unit.md
Name: data_access_unit

Overview:
- Memory-stage data access controller. It sits between the M pipeline stage and the single-port 32-bit data memory.
- Scalar loads and stores pass straight through to memory.
- A vector load or store of V lanes is serialized into V consecutive word beats. While the sequence runs, the block drives BusyDA, which stalls F/D/E/M/W through the hazard unit.
- On completion it presents the assembled vector and pulses DoneDA.

Parameters:
- N, 32, word/lane width in bits; one memory beat.
- V, 4, lanes per vector access. Must be ≥2. Vector width is V*N.
- A, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- MemReadM  in  1  M-stage load
- MemWriteM  in  1  M-stage store
- VecM  in  1  M-stage access is vector (V lanes)
- AddrM  in  A  byte address, base of the access
- WriteDataM  in  N  scalar store data
- WriteDataVM  in  V*N  vector store data; lane k = bits [k*N+N-1:k*N]
- mem_addr  out  A  memory byte address
- mem_wdata  out  N  memory write data
- mem_we  out  1  memory write enable
- mem_rdata  in  N  memory read data; synchronous, valid the cycle after the address
- ReadDataM  out  N  scalar load data (= mem_rdata)
- ReadDataVM  out  V*N  assembled vector load data, registered
- BusyDA  out  1  vector sequence in progress; to the hazard unit
- DoneDA  out  1  one-cycle pulse, vector access complete

Behaviour:
- States: IDLE, WRITE, READ, READ_LAST, DONE.
- Reset (asynchronous, while rst=1):
  - state=IDLE; beat counter=0; ReadDataVM=0; captured address/data registers=0.
  - mem_we=0, BusyDA=0, DoneDA=0 forced. mem_addr=0, mem_wdata=0.
- Vector request is defined as vreq = VecM & (MemReadM | MemWriteM).
- When both MemReadM and MemWriteM are high, the access is a write.
- Addressing:
  - Base is AddrM with its low log2(N/8) bits forced to 0.
  - Beat k uses base + k*(N/8), k = 0..V-1.
  - Lane 0 sits at the lowest address. Address arithmetic wraps modulo 2^A.
- IDLE, no vreq (scalar path):
  - mem_addr=AddrM; mem_wdata=WriteDataM; mem_we=MemWriteM & ~VecM.
  - BusyDA=0.
- IDLE, vreq (accept cycle T):
  - BusyDA=1 combinationally.
  - Beat 0 is issued this cycle. For a write, mem_we=1 and mem_wdata=lane 0.
  - Base address and WriteDataVM are captured into registers; counter=1.
  - Next state is WRITE or READ.
- WRITE:
  - Issue beat k from captured data with mem_we=1; BusyDA=1.
  - After beat V-1, go to DONE.
  - Store occupies cycles T..T+V-1; BusyDA high for V cycles.
- READ:
  - Issue read of beat k with mem_we=0; capture mem_rdata into lane k-1; BusyDA=1.
  - After issuing beat V-1, go to READ_LAST.
- READ_LAST:
  - Capture mem_rdata into lane V-1; BusyDA=1; no memory access (mem_we=0).
  - Next state is DONE.
  - Load therefore holds BusyDA for V+1 cycles (T..T+V).
- DONE:
  - BusyDA=0, DoneDA=1, mem_we=0. The pipeline advances at the end of this cycle.
  - vreq is ignored: it is the completing instruction still visible in M.
  - Next state is IDLE.
- ReadDataVM updates only during a vector read, lane by lane. It holds its value otherwise, including across scalar accesses and vector writes. The full vector is valid from the DONE cycle until the next vector read is accepted.
- Inputs are sampled only in IDLE. Changes to AddrM, WriteDataVM or WriteDataM in any other state have no effect.
- In READ, READ_LAST and DONE, MemWriteM cannot reach mem_we.
- Reset asserted mid-sequence aborts the sequence immediately:
  - No further beats are issued.
  - BusyDA drops in the same cycle rst rises.
  - After release, the block is in IDLE.
- Beat counter is log2(V)+1 bits wide; it never overflows.

Test Plan:
- Reset: assert rst mid-cycle with MemWriteM=1 → mem_we=0, BusyDA=0, DoneDA=0, ReadDataVM=0 immediately. After release, state IDLE.
- Vector store: VecM=1, MemWriteM=1, AddrM=0x103, WriteDataVM=0x44444444_33333333_22222222_11111111 →
  - mem_addr 0x100/0x104/0x108/0x10C with mem_we=1 on T..T+3; wdata 0x11111111..0x44444444.
  - BusyDA high exactly 4 cycles; DoneDA at T+4.
- Vector load: memory holds 0xA0,0xA1,0xA2,0xA3 at 0x200..0x20C →
  - BusyDA high T..T+4.
  - ReadDataVM=0x000000A3_000000A2_000000A1_000000A0 at T+5 (DONE); DoneDA at T+5; mem_we=0 throughout.
- Scalar passthrough: VecM=0, MemWriteM=1, AddrM=0x20, WriteDataM=0xDEADBEEF → same-cycle mem_we=1, mem_addr=0x20, BusyDA=0. A following scalar load returns 0xDEADBEEF on ReadDataM one cycle later.
- Back-to-back: vector load held in M through DONE, followed by vector store → the load is not re-issued in DONE; the store is accepted the cycle after DONE. Address wrap: AddrM=0xFFFFFFF8 produces beats 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
- Abort: rst pulsed at T+2 of a vector store → beats 2 and 3 are never written. After release, a new vector read completes with correct data and ReadDataVM overwritten.
